// File: rtl/uart_transmitter.sv
// uart_transmitter: ready/valid byte sink that serialises each accepted byte
// as an 8N1 frame on SOut (start bit, 8 data bits LSB first, stop bit).
// Every output comes straight from a flop, so DataIn and DataInValid have no
// combinational path to DataInReady or SOut.
//
// Optional build macro:
//   UART_TX_PARITY_EN - when defined, an even-parity bit is inserted between
//                       data bit 7 and the stop bit, which stretches the frame
//                       to 11 symbols. When undefined, no parity state or
//                       parity storage is built.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    // Clock cycles per serial symbol. This must be at least 2.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

    // The cycle counter is just wide enough to hold 0..SYMBOL_EDGE_TIME-1.
    localparam int CYCLE_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t             state_reg,     state_next;
    logic [CYCLE_W-1:0] cycle_cnt_reg, cycle_cnt_next;
    logic [2:0]         bit_cnt_reg,   bit_cnt_next;
    logic [7:0]         shift_reg,     shift_next;
    logic               sout_reg,      sout_next;
    logic               ready_reg,     ready_next;
`ifdef UART_TX_PARITY_EN
    // Parity is captured when the byte is accepted, because the shift
    // register loses the original byte as its bits are shifted out.
    logic               parity_reg,    parity_next;
`endif

    // This is high on the last cycle of the current symbol.
    logic bit_done;
    assign bit_done = (cycle_cnt_reg == LAST_CYCLE);

    assign DataInReady = ready_reg;
    assign SOut        = sout_reg;

    // State register. Reset is asynchronous, so an active reset forces the
    // line high and ready high at once, even in the middle of a frame.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cycle_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sout_reg      <= 1'b1;
            ready_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cycle_cnt_reg <= cycle_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            sout_reg      <= sout_next;
            ready_reg     <= ready_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    // Next-state logic. The value for SOut is computed one cycle ahead, so
    // that each symbol appears on the registered line exactly on its boundary.
    always_comb begin
        state_next     = state_reg;
        cycle_cnt_next = cycle_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        sout_next      = sout_reg;
        ready_next     = ready_reg;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        // Outside IDLE the cycle counter runs continuously and wraps on every
        // symbol boundary. It is never reloaded from anywhere else, so the bit
        // timing cannot drift during a frame.
        if (state_reg != IDLE) begin
            cycle_cnt_next = bit_done ? '0 : cycle_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                sout_next      = 1'b1;
                ready_next     = 1'b1;
                cycle_cnt_next = '0;
                bit_cnt_next   = '0;
                // Handshake. The start bit appears on the line in the next cycle.
                if (DataInValid && ready_reg) begin
                    state_next = START;
                    shift_next = DataIn;
                    sout_next  = 1'b0;
                    ready_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^DataIn;
`endif
                end
            end

            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    sout_next    = shift_reg[0];
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        sout_next  = parity_reg;
`else
                        state_next = STOP;
                        sout_next  = 1'b1;
`endif
                    end else begin
                        // Bit 1 of the current register becomes bit 0 after
                        // the shift, so put it on the line now.
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        sout_next    = shift_reg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    sout_next  = 1'b1;
                end
            end
`endif

            STOP: begin
                sout_next = 1'b1;
                // Ready rises together with the return to IDLE. A byte that is
                // already waiting can therefore be accepted on the first idle cycle.
                if (bit_done) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end
            end

            default: begin
                state_next     = IDLE;
                sout_next      = 1'b1;
                ready_next     = 1'b1;
                cycle_cnt_next = '0;
                bit_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: self-checking bench for uart_transmitter, run with N=10.
// A line monitor decodes each frame into rx_q. The scenario tasks push the
// bytes they expect into exp_q and compare the two queues.
// Each task also checks the line and ready level against a cycle-exact model.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int N          = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME   = FRAME_BITS * N;
    localparam int RX_WAIT = 300;

    logic       CLK;
    logic       reset;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic       SOut;

    int pass_cnt;
    int check_cnt;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       rx_err_q[$];

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOut       (SOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level at cycle i of a frame (cycle 0 is the first start-bit cycle).
    function automatic logic exp_line(input logic [7:0] b, input int i);
        int idx;
        idx = i / N;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line monitor. It samples the middle of each symbol and drops any frame
    // that is cut short by reset.
    logic [7:0] mon_data;
    logic       mon_err;
    logic       mon_abort;
    int         mon_idx;
    initial begin
        forever begin
            @(negedge CLK);
            if (reset === 1'b0 && SOut === 1'b0) begin
                mon_abort = 1'b0;
                mon_err   = 1'b0;
                mon_data  = '0;
                for (int c = 1; c < FRAME && !mon_abort; c++) begin
                    @(negedge CLK);
                    if (reset !== 1'b0) begin
                        mon_abort = 1'b1;
                    end else if (c % N == N / 2) begin
                        mon_idx = c / N;
                        if (mon_idx == 0) begin
                            if (SOut !== 1'b0) mon_err = 1'b1;
                        end else if (mon_idx <= 8) begin
                            mon_data[mon_idx-1] = SOut;
`ifdef UART_TX_PARITY_EN
                        end else if (mon_idx == 9) begin
                            if (SOut !== ^mon_data) mon_err = 1'b1;
`endif
                        end else begin
                            if (SOut !== 1'b1) mon_err = 1'b1;
                        end
                    end
                end
                if (!mon_abort) begin
                    rx_q.push_back(mon_data);
                    rx_err_q.push_back(mon_err);
                end
            end
        end
    end

    task automatic test_reset();
        int bad;
        // The bench starts with reset already asserted.
        check_cnt++;
        if ({SOut, DataInReady} !== 2'b11) $display("FAIL reset_hold: SOut,ready=%b want 11", {SOut, DataInReady});
        else pass_cnt++;
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if ({SOut, DataInReady} !== 2'b11) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL reset_release: %0d cycles not idle, want 0", bad);
        else pass_cnt++;

        // Reset while idle. Outputs are checked before the next clock edge.
        #1 reset = 1'b1;
        #1;
        check_cnt++;
        if ({SOut, DataInReady} !== 2'b11) $display("FAIL reset_idle: SOut,ready=%b want 11", {SOut, DataInReady});
        else pass_cnt++;
        @(negedge CLK);
        reset = 1'b0;

        // Reset and a handshake in the same cycle. Reset wins and the byte is lost.
        @(negedge CLK);
        DataIn = 8'h55; DataInValid = 1'b1; reset = 1'b1;
        @(negedge CLK);
        DataInValid = 1'b0; reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if ({SOut, DataInReady} !== 2'b11) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL reset_vs_accept: %0d cycles not idle, want 0", bad);
        else pass_cnt++;

        // Reset in the middle of a data bit (bit 1 of 0x00, cycle 25).
        DataIn = 8'h00; DataInValid = 1'b1;
        @(negedge CLK);
        DataInValid = 1'b0;
        repeat (25) @(negedge CLK);
        check_cnt++;
        if (SOut !== 1'b0) $display("FAIL reset_pre_data: SOut=%b want 0", SOut);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        check_cnt++;
        if ({SOut, DataInReady} !== 2'b11) $display("FAIL reset_mid_data: SOut,ready=%b want 11", {SOut, DataInReady});
        else pass_cnt++;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if ({SOut, DataInReady} !== 2'b11) bad++;
        end
        check_cnt++;
        if (bad !== 0 || rx_q.size() !== 0) $display("FAIL reset_after_frame: %0d busy cycles, %0d frames decoded, want 0/0", bad, rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_single_byte();
        int line_err, rdy_err, first_bad;
        logic [7:0] got, want;
        logic       ferr;
        line_err = 0; rdy_err = 0; first_bad = -1;
        @(negedge CLK);
        check_cnt++;
        if (DataInReady !== 1'b1) $display("FAIL single_ready_pre: ready=%b want 1", DataInReady);
        else pass_cnt++;
        DataIn = 8'hA5; DataInValid = 1'b1; exp_q.push_back(8'hA5);
        @(negedge CLK);
        DataInValid = 1'b0; DataIn = 8'h00;
        for (int i = 0; i < FRAME; i++) begin
            if (SOut !== exp_line(8'hA5, i)) begin
                if (first_bad < 0) first_bad = i;
                line_err++;
            end
            if (DataInReady !== 1'b0) rdy_err++;
            @(negedge CLK);
        end
        check_cnt++;
        if (line_err !== 0) $display("FAIL single_line: %0d wrong cycles (first %0d), want 0", line_err, first_bad);
        else pass_cnt++;
        check_cnt++;
        if (rdy_err !== 0) $display("FAIL single_ready_busy: ready high on %0d busy cycles, want 0", rdy_err);
        else pass_cnt++;
        check_cnt++;
        if ({SOut, DataInReady} !== 2'b11) $display("FAIL single_end: SOut,ready=%b want 11", {SOut, DataInReady});
        else pass_cnt++;
        for (int k = 0; k < RX_WAIT && rx_q.size() == 0; k++) @(negedge CLK);
        check_cnt++;
        if (rx_q.size() == 0) begin
            $display("FAIL single_rx: no frame within %0d cycles, want 0xa5", RX_WAIT);
        end else begin
            got = rx_q.pop_front(); ferr = rx_err_q.pop_front(); want = exp_q.pop_front();
            if ({ferr, got} !== {1'b0, want}) $display("FAIL single_rx: got 0x%h err=%b want 0x%h err=0", got, ferr, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_drop();
        int line_err, rdy_err, idle_err;
        logic [7:0] got, want;
        logic       ferr;
        line_err = 0; rdy_err = 0; idle_err = 0;
        @(negedge CLK);
        DataIn = 8'hA5; DataInValid = 1'b1; exp_q.push_back(8'hA5);
        @(negedge CLK);
        DataInValid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (SOut !== exp_line(8'hA5, i)) line_err++;
            if (DataInReady !== 1'b0) rdy_err++;
            if (i == 40) begin
                DataIn = 8'h3C; DataInValid = 1'b1;
            end else begin
                DataInValid = 1'b0;
            end
            @(negedge CLK);
        end
        repeat (120) begin
            if ({SOut, DataInReady} !== 2'b11) idle_err++;
            @(negedge CLK);
        end
        check_cnt++;
        if (line_err !== 0) $display("FAIL busy_line: %0d wrong cycles, want 0", line_err);
        else pass_cnt++;
        check_cnt++;
        if (rdy_err !== 0) $display("FAIL busy_ready: ready high on %0d busy cycles, want 0", rdy_err);
        else pass_cnt++;
        check_cnt++;
        if (idle_err !== 0) $display("FAIL busy_idle: %0d non-idle cycles after frame, want 0", idle_err);
        else pass_cnt++;
        check_cnt++;
        if (rx_q.size() == 0) begin
            $display("FAIL busy_rx: no frame decoded, want 0xa5");
        end else begin
            got = rx_q.pop_front(); ferr = rx_err_q.pop_front(); want = exp_q.pop_front();
            if ({ferr, got} !== {1'b0, want}) $display("FAIL busy_rx: got 0x%h err=%b want 0x%h err=0", got, ferr, want);
            else pass_cnt++;
        end
        check_cnt++;
        if (rx_q.size() !== 0) $display("FAIL busy_extra: %0d extra frames, want 0", rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int line_err, rdy_err, first_bad;
        logic exp_s, exp_r;
        logic [7:0] got, want;
        logic       ferr;
        line_err = 0; rdy_err = 0; first_bad = -1;
        @(negedge CLK);
        DataIn = 8'h00; DataInValid = 1'b1; exp_q.push_back(8'h00);
        @(negedge CLK);
        DataIn = 8'hFF; exp_q.push_back(8'hFF);
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i < FRAME)       exp_s = exp_line(8'h00, i);
            else if (i == FRAME) exp_s = 1'b1;
            else                 exp_s = exp_line(8'hFF, i - FRAME - 1);
            exp_r = (i == FRAME);
            if (SOut !== exp_s) begin
                if (first_bad < 0) first_bad = i;
                line_err++;
            end
            if (DataInReady !== exp_r) rdy_err++;
            if (i == FRAME + 1) DataInValid = 1'b0;
            @(negedge CLK);
        end
        check_cnt++;
        if (line_err !== 0) $display("FAIL b2b_line: %0d wrong cycles (first %0d), want 0", line_err, first_bad);
        else pass_cnt++;
        check_cnt++;
        if (rdy_err !== 0) $display("FAIL b2b_ready: %0d wrong ready cycles, want 0", rdy_err);
        else pass_cnt++;
        check_cnt++;
        if ({SOut, DataInReady} !== 2'b11) $display("FAIL b2b_end: SOut,ready=%b want 11", {SOut, DataInReady});
        else pass_cnt++;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < RX_WAIT && rx_q.size() == 0; k++) @(negedge CLK);
            check_cnt++;
            if (rx_q.size() == 0) begin
                $display("FAIL b2b_rx%0d: no frame decoded within %0d cycles", f, RX_WAIT);
            end else begin
                got = rx_q.pop_front(); ferr = rx_err_q.pop_front(); want = exp_q.pop_front();
                if ({ferr, got} !== {1'b0, want}) $display("FAIL b2b_rx%0d: got 0x%h err=%b want 0x%h err=0", f, got, ferr, want);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        int line_err, rdy_err, first_bad;
        logic [7:0] got, want;
        logic       ferr;
        line_err = 0; rdy_err = 0; first_bad = -1;
        @(negedge CLK);
        DataIn = 8'h00; DataInValid = 1'b1;
        @(negedge CLK);
        DataInValid = 1'b0;
        repeat (35) @(negedge CLK);
        #1 reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        DataIn = 8'h81; DataInValid = 1'b1; exp_q.push_back(8'h81);
        @(negedge CLK);
        DataInValid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (SOut !== exp_line(8'h81, i)) begin
                if (first_bad < 0) first_bad = i;
                line_err++;
            end
            if (DataInReady !== 1'b0) rdy_err++;
            @(negedge CLK);
        end
        check_cnt++;
        if (line_err !== 0) $display("FAIL midrst_line: %0d wrong cycles (first %0d), want 0", line_err, first_bad);
        else pass_cnt++;
        check_cnt++;
        if (rdy_err !== 0) $display("FAIL midrst_ready: ready high on %0d busy cycles, want 0", rdy_err);
        else pass_cnt++;
        for (int k = 0; k < RX_WAIT && rx_q.size() == 0; k++) @(negedge CLK);
        check_cnt++;
        if (rx_q.size() == 0) begin
            $display("FAIL midrst_rx: no frame decoded, want 0x81");
        end else begin
            got = rx_q.pop_front(); ferr = rx_err_q.pop_front(); want = exp_q.pop_front();
            if ({ferr, got} !== {1'b0, want}) $display("FAIL midrst_rx: got 0x%h err=%b want 0x%h err=0", got, ferr, want);
            else pass_cnt++;
        end
        repeat (20) @(negedge CLK);
        check_cnt++;
        if (rx_q.size() !== 0) $display("FAIL midrst_extra: %0d extra frames, want 0", rx_q.size());
        else pass_cnt++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par_want [2];
        int line_err, rdy_err;
        logic par_got;
        logic [7:0] got, want;
        logic       ferr;
        bytes[0] = 8'hA5; par_want[0] = 1'b0;
        bytes[1] = 8'h07; par_want[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            line_err = 0; rdy_err = 0; par_got = 1'bx;
            @(negedge CLK);
            DataIn = bytes[t]; DataInValid = 1'b1; exp_q.push_back(bytes[t]);
            @(negedge CLK);
            DataInValid = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                if (SOut !== exp_line(bytes[t], i)) line_err++;
                if (DataInReady !== 1'b0) rdy_err++;
                if (i == 9 * N + N / 2) par_got = SOut;
                @(negedge CLK);
            end
            check_cnt++;
            if (par_got !== par_want[t]) $display("FAIL parity_bit%0d: got %b want %b", t, par_got, par_want[t]);
            else pass_cnt++;
            check_cnt++;
            if (line_err !== 0 || rdy_err !== 0) $display("FAIL parity_frame%0d: %0d line / %0d ready errors, want 0/0", t, line_err, rdy_err);
            else pass_cnt++;
            check_cnt++;
            if (DataInReady !== 1'b1) $display("FAIL parity_end%0d: ready=%b want 1", t, DataInReady);
            else pass_cnt++;
            for (int k = 0; k < RX_WAIT && rx_q.size() == 0; k++) @(negedge CLK);
            check_cnt++;
            if (rx_q.size() == 0) begin
                $display("FAIL parity_rx%0d: no frame decoded", t);
            end else begin
                got = rx_q.pop_front(); ferr = rx_err_q.pop_front(); want = exp_q.pop_front();
                if ({ferr, got} !== {1'b0, want}) $display("FAIL parity_rx%0d: got 0x%h err=%b want 0x%h err=0", t, got, ferr, want);
                else pass_cnt++;
            end
        end
    endtask
`endif

    initial begin
        pass_cnt    = 0;
        check_cnt   = 0;
        reset       = 1'b1;
        DataIn      = 8'h00;
        DataInValid = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_single_byte();
        test_busy_drop();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
